// File: rtl/ps2_key_ctrl.sv
// rtl/ps2_key_ctrl.sv - PS/2 scan-code prefix decoder with event FIFO and processor port interface
module ps2_key_ctrl #(
  parameter int         DEPTH_LOG2  = 3,
  parameter logic [7:0] DATA_PORT   = 8'h70,
  parameter logic [7:0] STATUS_PORT = 8'h71,
  parameter int         TIMEOUT_CYC = 1000000
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Rx_Done_Tick,
  input  logic [7:0] Rx_Data,
  output logic       RX_En,
  input  logic [7:0] ID_Port,
  input  logic       Read_Strobe,
  output logic [7:0] Data_Out,
  output logic       Key_Ready
);

  localparam int              DEPTH    = 2 ** DEPTH_LOG2;
  localparam int              CW       = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [31:0]     TMO_LAST = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t                  state, state_next;
  logic [31:0]             tmo_cnt;
  logic                    push;
  logic [9:0]              push_data;
  logic [9:0]              mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]           count, count_next;
  logic                    overflow;
  logic                    pop, full, wr_en, ovf_set, ovf_clr, nonempty;
  logic [9:0]              head;
  logic [31:0]             cnt_w;
  logic [3:0]              cnt4;

  // Prefix decoder: E0 marks extended, F0 marks break; a repeated E0 in EXT is absorbed.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    push_data  = {2'b00, Rx_Data};
    if (Rx_Done_Tick) begin
      case (state)
        IDLE: begin
          if (Rx_Data == 8'hE0)      state_next = EXT;
          else if (Rx_Data == 8'hF0) state_next = BRK;
          else                       push = 1'b1;
        end
        EXT: begin
          if (Rx_Data == 8'hF0)      state_next = EXT_BRK;
          else if (Rx_Data == 8'hE0) state_next = EXT;
          else begin
            push       = 1'b1;
            push_data  = {2'b10, Rx_Data};
            state_next = IDLE;
          end
        end
        BRK: begin
          push       = 1'b1;
          push_data  = {2'b01, Rx_Data};
          state_next = IDLE;
        end
        default: begin
          push       = 1'b1;
          push_data  = {2'b11, Rx_Data};
          state_next = IDLE;
        end
      endcase
    end else if (state != IDLE && tmo_cnt == TMO_LAST) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (!Reset || Rx_Done_Tick || state == IDLE || tmo_cnt == TMO_LAST) tmo_cnt <= '0;
    else tmo_cnt <= tmo_cnt + 32'd1;
  end

  // A pop in the same cycle frees a slot, so a push at full still lands.
  assign nonempty = (count != '0);
  assign full     = (count == DEPTH_C);
  assign pop      = Read_Strobe && (ID_Port == DATA_PORT) && nonempty;
  assign wr_en    = push && (!full || pop);
  assign ovf_set  = push && full && !pop;
  assign ovf_clr  = Read_Strobe && (ID_Port == STATUS_PORT);

  always_comb begin
    count_next = count;
    if (wr_en && !pop)      count_next = count + 1'b1;
    else if (!wr_en && pop) count_next = count - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      RX_En     <= 1'b1;
      Key_Ready <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      RX_En     <= (count_next < DEPTH_C);
      Key_Ready <= (count_next != '0);
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign head  = mem[rd_ptr];
  assign cnt_w = 32'(count);
  assign cnt4  = (cnt_w > 32'd15) ? 4'hF : cnt_w[3:0];

  always_comb begin
    Data_Out = 8'h00;
    if (ID_Port == DATA_PORT) begin
      Data_Out = nonempty ? head[7:0] : 8'h00;
    end else if (ID_Port == STATUS_PORT) begin
      Data_Out = {nonempty, overflow, nonempty & head[8], nonempty & head[9], cnt4};
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb/tb_ps2_key_ctrl.sv - scoreboard bench for ps2_key_ctrl
module tb_ps2_key_ctrl;

  localparam int TMO = 50;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic       Rx_Done_Tick = 1'b0;
  logic [7:0] Rx_Data = 8'h00;
  logic       RX_En;
  logic [7:0] ID_Port = 8'h00;
  logic       Read_Strobe = 1'b0;
  logic [7:0] Data_Out;
  logic       Key_Ready;
  logic       probe = 1'b0;

  typedef struct {
    bit         kind;
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  ps2_key_ctrl #(
    .DEPTH_LOG2(3),
    .DATA_PORT(8'h70),
    .STATUS_PORT(8'h71),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .CLK(CLK),
    .Reset(Reset),
    .Rx_Done_Tick(Rx_Done_Tick),
    .Rx_Data(Rx_Data),
    .RX_En(RX_En),
    .ID_Port(ID_Port),
    .Read_Strobe(Read_Strobe),
    .Data_Out(Data_Out),
    .Key_Ready(Key_Ready)
  );

  always #5 CLK = ~CLK;

  // Monitor: kind 0 compares Data_Out, kind 1 compares {RX_En, Key_Ready}.
  always @(negedge CLK) begin
    if (Reset && (Read_Strobe || probe)) begin
      exp_t e;
      logic [7:0] act;
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: no expected entry queued, Data_Out=%02h", Data_Out);
      end else begin
        e   = q.pop_front();
        act = e.kind ? {6'b0, RX_En, Key_Ready} : Data_Out;
        if (act !== e.val) begin
          n_err++;
          $display("FAIL %s: got %02h expected %02h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic tick(input logic [7:0] b);
    Rx_Done_Tick = 1'b1;
    Rx_Data      = b;
    @(posedge CLK); #1;
    Rx_Done_Tick = 1'b0;
  endtask

  task automatic rd(input logic [7:0] id, input logic [7:0] e, input string nm);
    ID_Port     = id;
    Read_Strobe = 1'b1;
    q.push_back('{1'b0, nm, e});
    @(posedge CLK); #1;
    Read_Strobe = 1'b0;
  endtask

  task automatic peek(input logic [7:0] id, input logic [7:0] e, input string nm);
    ID_Port = id;
    probe   = 1'b1;
    q.push_back('{1'b0, nm, e});
    @(posedge CLK); #1;
    probe = 1'b0;
  endtask

  task automatic flags(input logic rx_en, input logic key_ready, input string nm);
    probe = 1'b1;
    q.push_back('{1'b1, nm, {6'b0, rx_en, key_ready}});
    @(posedge CLK); #1;
    probe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    // Reset with random inputs
    Reset = 1'b0;
    repeat (2) begin
      Rx_Done_Tick = 1'($urandom);
      Rx_Data      = 8'($urandom);
      Read_Strobe  = 1'($urandom);
      ID_Port      = 8'($urandom);
      @(posedge CLK); #1;
    end
    Reset = 1'b1; Rx_Done_Tick = 1'b0; Read_Strobe = 1'b0; ID_Port = 8'h00;
    flags(1'b1, 1'b0, "reset_flags");
    peek(8'h71, 8'h00, "reset_status");
    peek(8'h55, 8'h00, "other_port");

    // Prefix decoding
    tick(8'h1C);
    tick(8'hF0); tick(8'h1C);
    tick(8'hE0); tick(8'h75);
    tick(8'hE0); tick(8'hF0); tick(8'h75);
    peek(8'h71, 8'h84, "status_plain");
    rd(8'h70, 8'h1C, "pop_plain");
    peek(8'h71, 8'hA3, "status_brk");
    rd(8'h70, 8'h1C, "pop_brk");
    peek(8'h71, 8'h92, "status_ext");
    rd(8'h70, 8'h75, "pop_ext");
    peek(8'h71, 8'hB1, "status_ext_brk");
    rd(8'h70, 8'h75, "pop_ext_brk");
    peek(8'h71, 8'h00, "status_drained");
    flags(1'b1, 1'b0, "flags_drained");

    // Prefix timeout: abandoned E0, then just inside the window
    tick(8'hE0);
    idle(TMO);
    tick(8'h1C);
    peek(8'h71, 8'h81, "status_after_timeout");
    rd(8'h70, 8'h1C, "pop_after_timeout");
    tick(8'hE0);
    idle(TMO - 2);
    tick(8'h1C);
    peek(8'h71, 8'h91, "status_before_timeout");
    rd(8'h70, 8'h1C, "pop_before_timeout");

    // Fill and overflow
    for (int i = 1; i <= 9; i++) begin
      tick(8'(i));
      if (i == 8) flags(1'b0, 1'b1, "flags_full");
    end
    rd(8'h71, 8'hC8, "status_overflow");
    peek(8'h71, 8'h88, "status_ovf_cleared");
    rd(8'h70, 8'h01, "pop_first_full");
    flags(1'b1, 1'b1, "flags_after_pop");

    // Refill, then push and pop in the same cycle at full
    tick(8'h0C);
    flags(1'b0, 1'b1, "flags_refilled");
    Rx_Done_Tick = 1'b1; Rx_Data = 8'h0A;
    ID_Port = 8'h70; Read_Strobe = 1'b1;
    q.push_back('{1'b0, "pop_push_same_cycle", 8'h02});
    @(posedge CLK); #1;
    Rx_Done_Tick = 1'b0; Read_Strobe = 1'b0;
    peek(8'h71, 8'h88, "status_push_pop_full");
    for (int i = 3; i <= 8; i++) rd(8'h70, 8'(i), "pop_drain");
    rd(8'h70, 8'h0C, "pop_refill");
    rd(8'h70, 8'h0A, "pop_tail");

    // Empty pop and reset mid-prefix
    rd(8'h70, 8'h00, "pop_empty");
    peek(8'h71, 8'h00, "status_empty");
    tick(8'h33);
    rd(8'h70, 8'h33, "pop_after_empty");
    tick(8'hE0);
    Reset = 1'b0;
    @(posedge CLK); #1;
    Reset = 1'b1;
    tick(8'h1C);
    peek(8'h71, 8'h81, "status_after_reset");
    rd(8'h70, 8'h1C, "pop_after_reset");
    flags(1'b1, 1'b0, "flags_end");

    idle(3);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
